// File: rtl/xt_bus_arbiter.sv
// XT system bus hold/acknowledge arbiter.
// Hands the bus from the CPU (via the 8288 address_enable_n) to the DMA controller.
// It waits for a passive bus with LOCK released, floats the CPU, stalls it and then grants HLDA.
// Release mirrors the handoff and is followed by a minimum CPU ownership window.
module xt_bus_arbiter #(
    parameter int unsigned HANDOFF_CYCLES = 2,
    parameter int unsigned RELEASE_CYCLES = 1,
    parameter int unsigned CPU_MIN_OWN    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] processor_status,
    input  logic       lock_n,
    input  logic       dma_hold_request,
    output logic       dma_hold_acknowledge,
    output logic       address_enable_n,
    output logic       dma_address_enable,
    output logic       cpu_wait
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_HANDOFF = 3'd2;
    localparam logic [2:0] ST_GRANTED = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [3:0] HANDOFF_LOAD = 4'(HANDOFF_CYCLES - 1);
    localparam logic [3:0] RELEASE_LOAD = 4'(RELEASE_CYCLES - 1);
    localparam logic [3:0] OWN_LOAD     = 4'(CPU_MIN_OWN);

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [1:0] r_passive;
    logic [1:0] w_passive_next;
    logic [3:0] r_own;
    logic [3:0] w_own_next;
    logic [3:0] r_guard;
    logic [3:0] w_guard_next;
    logic       w_bus_idle;

    // Two or more consecutive passive status samples mean no CPU cycle is in flight.
    assign w_bus_idle = r_passive[1];

    // Saturating run-length of passive status samples; tracked in every state.
    always_comb begin
        w_passive_next = 2'b00;
        if (processor_status == 3'b111) begin
            w_passive_next = (r_passive == 2'b11) ? 2'b11 : r_passive + 2'b01;
        end
    end

    // Next state plus guard and ownership timers.
    always_comb begin
        w_state_next = r_state;
        w_guard_next = r_guard;
        w_own_next   = r_own;
        case (r_state)
            ST_IDLE: begin
                if (r_own != 4'd0) w_own_next = r_own - 4'd1;
                if (dma_hold_request) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_own != 4'd0) w_own_next = r_own - 4'd1;
                if (!dma_hold_request) begin
                    w_state_next = ST_IDLE;
                end else if (w_bus_idle && lock_n && (r_own == 4'd0)) begin
                    w_state_next = ST_HANDOFF;
                    w_guard_next = HANDOFF_LOAD;
                end
            end
            ST_HANDOFF: begin
                // Handoff always runs to completion; a lost request backs out via RELEASE.
                if (r_guard == 4'd0) begin
                    if (dma_hold_request) begin
                        w_state_next = ST_GRANTED;
                    end else begin
                        w_state_next = ST_RELEASE;
                        w_guard_next = RELEASE_LOAD;
                    end
                end else begin
                    w_guard_next = r_guard - 4'd1;
                end
            end
            ST_GRANTED: begin
                if (!dma_hold_request) begin
                    w_state_next = ST_RELEASE;
                    w_guard_next = RELEASE_LOAD;
                end
            end
            ST_RELEASE: begin
                if (r_guard == 4'd0) begin
                    w_state_next = ST_IDLE;
                    w_own_next   = OWN_LOAD;
                end else begin
                    w_guard_next = r_guard - 4'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_passive <= 2'b00;
            r_own     <= 4'd0;
            r_guard   <= 4'd0;
        end else begin
            r_state   <= w_state_next;
            r_passive <= w_passive_next;
            r_own     <= w_own_next;
            r_guard   <= w_guard_next;
        end
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        dma_hold_acknowledge = 1'b0;
        address_enable_n     = 1'b0;
        dma_address_enable   = 1'b0;
        cpu_wait             = 1'b0;
        case (r_state)
            ST_HANDOFF, ST_RELEASE: begin
                address_enable_n   = 1'b1;
                dma_address_enable = 1'b1;
                cpu_wait           = 1'b1;
            end
            ST_GRANTED: begin
                dma_hold_acknowledge = 1'b1;
                address_enable_n     = 1'b1;
                dma_address_enable   = 1'b1;
                cpu_wait             = 1'b1;
            end
            default: begin
                dma_hold_acknowledge = 1'b0;
            end
        endcase
    end

endmodule
